bcd2bin: RTL and testbench
==========================

# bcd2bin

Sequential BCD-to-binary converter, the inverse of the scale's binary-to-BCD display path. It takes a packed 4-digit BCD value from the keypad/tare-entry logic and returns its binary equivalent using reverse double-dabble, one shift per clock. A start/done handshake lets the control FSM load a user-entered setpoint or tare into the binary weight datapath.

## Interface
- DIGITS, 4, number of packed BCD digits on bcd_in; digit 0 is bits [3:0].
- BIN_W, 15, width of the binary result and number of shift iterations; must satisfy 10^DIGITS - 1 < 2^BIN_W.
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- start  input  1  request conversion; sampled only when busy = 0.
- bcd_in  input  4*DIGITS  packed BCD operand; captured on the accepted start cycle.
- bin  output  BIN_W  binary result; registered, held until the next completion.
- done  output  1  one-cycle completion pulse.
- err  output  1  last accepted operand had a digit > 9; held until the next accepted start.
- busy  output  1  conversion in progress; start is ignored while high.

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy = 0. When start = 1, capture bcd_in into sh_bcd, clear sh_bin (BIN_W bits), clear cnt, clear err.
  - If any nibble of bcd_in is > 9: err <= 1, bin <= 0, go to DONE. No shifting.
  - Otherwise go to SHIFT.
- SHIFT, one iteration per cycle, BIN_W iterations (cnt = 0 .. BIN_W-1):
  - Concatenation {sh_bcd, sh_bin} shifts right by 1. sh_bcd[0] enters sh_bin[BIN_W-1], and 0 enters sh_bcd[MSB].
  - After the shift, every nibble of sh_bcd that is >= 8 has 3 subtracted in the same cycle. Use 4-bit arithmetic per nibble, with no carry between nibbles.
  - On the final iteration, load the shifted sh_bin into bin and go to DONE.
- DONE: done = 1 for exactly one cycle, busy = 1, then go to IDLE.
- bin changes only on the edge entering DONE. err changes only on an accepted start, or on entry to DONE via the error path.
- start is ignored in SHIFT and DONE. There is no queuing, and the operand is not re-sampled.

## Timing
- Reset values: bin = 0, done = 0, err = 0, busy = 0, state = IDLE, cnt = 0.
- Reset asserted mid-conversion: the next edge returns the block to IDLE with the reset values. No done pulse follows, and the operand is discarded.
- Valid operand, start high in cycle 0:
  - busy is high in cycles 1 .. BIN_W+1.
  - SHIFT occupies cycles 1 .. BIN_W.
  - done and the new bin appear in cycle BIN_W+1 (cycle 16 with defaults).
  - The earliest next accepted start is cycle BIN_W+2.
- Invalid operand, start high in cycle 0:
  - done = 1, err = 1, bin = 0, and busy = 1 in cycle 1.
  - The earliest next start is cycle 2.
- start held high continuously: a new conversion is accepted in each IDLE cycle. Each conversion is back-to-back, separated only by one IDLE cycle.
- err and bin are valid together with done and remain stable until the next conversion result.
- Maximum input 9999 yields 0x270F, with bin[BIN_W-1] = 0 for default parameters.

## Test plan
- Reset: hold rst 2 cycles -> bin = 0, done = 0, err = 0, busy = 0.
- Basic conversion:
  - start with bcd_in = 16'h1234 at cycle 0 -> done pulses for one cycle in cycle 16 with bin = 15'd1234 (0x04D2) and err = 0.
  - busy is high in cycles 1-16.
- Boundary values:
  - 16'h0000 -> bin = 0.
  - 16'h9999 -> bin = 9999 (0x270F).
  - 16'h0009 -> bin = 9.
  - 16'h1000 -> bin = 1000.
  - In each case done arrives exactly 16 cycles after start.
- Invalid digit: bcd_in = 16'h9A00 -> done and err high in cycle 1, bin = 0, no SHIFT cycles. A following valid start (16'h0042) clears err and yields bin = 42.
- Start while busy: start pulse with 16'h0500, then start with 16'h0777 in cycles 5 and 16 -> both ignored, result bin = 500. A start in cycle 17 is accepted and yields 777 in cycle 33.
- Reset mid-operation: start 16'h4321, assert rst in cycle 8 -> no done pulse, bin = 0, busy = 0. The next conversion of 16'h4321 yields 4321 normally.

Source files
------------

// File: rtl/bcd2bin_if.sv
// bcd2bin_if
//   Handshake bundle between the control FSM (master) and the BCD-to-binary
//   converter (slave).
//   start  : request a conversion (master -> slave)
//   bcd_in : packed BCD operand, digit 0 in bits [3:0] (master -> slave)
//   bin    : registered binary result (slave -> master)
//   done   : one-cycle completion pulse (slave -> master)
//   err    : last accepted operand contained a digit > 9 (slave -> master)
//   busy   : conversion in progress, start ignored (slave -> master)
interface bcd2bin_if #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 15
) ();
  logic                  start;
  logic [4*DIGITS-1:0]   bcd_in;
  logic [BIN_W-1:0]      bin;
  logic                  done;
  logic                  err;
  logic                  busy;

  modport master (
    output start, bcd_in,
    input  bin, done, err, busy
  );

  modport slave (
    input  start, bcd_in,
    output bin, done, err, busy
  );
endinterface

// File: rtl/bcd2bin.sv
// bcd2bin
//   Sequential BCD-to-binary converter using reverse double-dabble, one shift
//   per clock. Used to load keypad-entered setpoints/tare into the binary
//   weight datapath.
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : bcd2bin_if.slave (start, bcd_in in; bin, done, err, busy out)
//
//   state | meaning
//   IDLE  | waiting for start; operand captured and validated on start
//   SHIFT | one shift-and-correct iteration per cycle, BIN_W iterations
//   DONE  | done pulse for one cycle, result/err valid, then back to IDLE
module bcd2bin #(
  parameter int DIGITS = 4,
  parameter int BIN_W  = 15
) (
  input logic     clk,
  input logic     rst,
  bcd2bin_if.slave bus
);
  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t             state_q, state_d;
  logic [BCD_W-1:0]   sh_bcd_q, sh_bcd_d;
  logic [BIN_W-1:0]   sh_bin_q, sh_bin_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic               bad_digit;
  logic [BCD_W-1:0]   shr_bcd;
  logic [BCD_W-1:0]   adj_bcd;
  logic [BIN_W-1:0]   shr_bin;

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bus.bcd_in[4*i +: 4] > 4'd9) bad_digit = 1'b1;
    end
  end

  // Right shift of {sh_bcd, sh_bin}, then per-nibble -3 correction on any
  // digit that went to 8 or above (the undo of double-dabble's +3).
  always_comb begin
    shr_bin = {sh_bcd_q[0], sh_bin_q[BIN_W-1:1]};
    shr_bcd = {1'b0, sh_bcd_q[BCD_W-1:1]};
    adj_bcd = shr_bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (shr_bcd[4*i +: 4] >= 4'd8) adj_bcd[4*i +: 4] = shr_bcd[4*i +: 4] - 4'd3;
    end
  end

  always_comb begin
    state_d  = state_q;
    sh_bcd_d = sh_bcd_q;
    sh_bin_d = sh_bin_q;
    bin_d    = bin_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sh_bcd_d = bus.bcd_in;
          sh_bin_d = '0;
          cnt_d    = '0;
          err_d    = 1'b0;
          if (bad_digit) begin
            err_d   = 1'b1;
            bin_d   = '0;
            state_d = DONE;
          end else begin
            state_d = SHIFT;
          end
        end
      end
      SHIFT: begin
        sh_bcd_d = adj_bcd;
        sh_bin_d = shr_bin;
        cnt_d    = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(BIN_W - 1)) begin
          bin_d   = shr_bin;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sh_bcd_q <= '0;
      sh_bin_q <= '0;
      bin_q    <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_bcd_q <= sh_bcd_d;
      sh_bin_q <= sh_bin_d;
      bin_q    <= bin_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  assign bus.bin  = bin_q;
  assign bus.err  = err_q;
  assign bus.done = (state_q == DONE);
  assign bus.busy = (state_q != IDLE);
endmodule

// File: tb/tb_bcd2bin.sv
// tb_bcd2bin
//   Directed bench for bcd2bin with a queue scoreboard: expected results are
//   pushed when a start is driven and popped when done is seen.
module tb_bcd2bin;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  bcd2bin_if #(.DIGITS(4), .BIN_W(15)) bus ();

  bcd2bin #(.DIGITS(4), .BIN_W(15)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [14:0] bin;
    logic        err;
    int          lat;
  } exp_t;

  exp_t sb[$];

  // Reference: decimal value of the BCD digits, or error if any digit > 9.
  function automatic exp_t model(input logic [15:0] b);
    exp_t r;
    int   v;
    logic e;
    logic [3:0] nib;
    v = 0;
    e = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      nib = b[4*i +: 4];
      if (nib > 4'd9) e = 1'b1;
      v = v * 10 + int'(nib);
    end
    r.err = e;
    r.bin = e ? 15'd0 : v[14:0];
    r.lat = e ? 1 : 16;
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with the block idle: drives one start cycle, waits
  // (bounded) for done, checks latency/result, then checks the pulse ends.
  task automatic run_conv(input string tag, input logic [15:0] bcd);
    exp_t e;
    int   k;
    bus.start  = 1'b1;
    bus.bcd_in = bcd;
    sb.push_back(model(bcd));
    @(negedge clk);
    bus.start = 1'b0;
    k = 1;
    while (bus.done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_done_seen"}, 32'(bus.done), 32'd1);
    e = sb.pop_front();
    chk({tag, "_latency"}, 32'(k), 32'(e.lat));
    chk({tag, "_bin"}, 32'(bus.bin), 32'(e.bin));
    chk({tag, "_err"}, 32'(bus.err), 32'(e.err));
    chk({tag, "_busy_at_done"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 32'(bus.done), 32'd0);
    chk({tag, "_idle_after"}, 32'(bus.busy), 32'd0);
    chk({tag, "_bin_held"}, 32'(bus.bin), 32'(e.bin));
  endtask

  initial begin
    exp_t e;
    rst        = 1'b1;
    bus.start  = 1'b0;
    bus.bcd_in = '0;

    // Reset
    @(negedge clk);
    @(negedge clk);
    chk("rst_bin", 32'(bus.bin), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic conversion, with busy tracked across the whole window
    bus.start  = 1'b1;
    bus.bcd_in = 16'h1234;
    sb.push_back(model(16'h1234));
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      chk("basic_busy", 32'(bus.busy), 32'd1);
      chk("basic_done_timing", 32'(bus.done), 32'(k == 16));
      if (k == 16) begin
        e = sb.pop_front();
        chk("basic_bin", 32'(bus.bin), 32'(e.bin));
        chk("basic_err", 32'(bus.err), 32'(e.err));
      end
      @(negedge clk);
    end
    chk("basic_done_off", 32'(bus.done), 32'd0);
    chk("basic_busy_off", 32'(bus.busy), 32'd0);

    // Boundary operands
    run_conv("b0000", 16'h0000);
    run_conv("b9999", 16'h9999);
    run_conv("b0009", 16'h0009);
    run_conv("b1000", 16'h1000);
    run_conv("b5078", 16'h5078);

    // Invalid digit, then a valid operand clears err
    run_conv("bad9A00", 16'h9A00);
    run_conv("after_bad", 16'h0042);
    run_conv("bad000F", 16'h000F);

    // Starts during SHIFT and DONE are ignored
    bus.start  = 1'b1;
    bus.bcd_in = 16'h0500;
    sb.push_back(model(16'h0500));
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      bus.start  = (k == 5 || k == 16);
      bus.bcd_in = 16'h0777;
      chk("ign_done_timing", 32'(bus.done), 32'(k == 16));
      if (k == 16) begin
        e = sb.pop_front();
        chk("ign_bin", 32'(bus.bin), 32'(e.bin));
      end
      @(negedge clk);
    end
    run_conv("after_ign", 16'h0777);

    // Reset in the middle of a conversion
    bus.start  = 1'b1;
    bus.bcd_in = 16'h4321;
    @(negedge clk);
    bus.start = 1'b0;
    for (int k = 1; k < 8; k++) begin
      chk("midrst_no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_done", 32'(bus.done), 32'd0);
    chk("midrst_bin", 32'(bus.bin), 32'd0);
    for (int k = 0; k < 20; k++) begin
      chk("midrst_quiet", 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    run_conv("after_rst", 16'h4321);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
